// File: rtl/uart9_pkg.sv
// Shared types and constants for the 9-bit multidrop UART transmitter.
package uart9_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} state_e;

  localparam int unsigned FRAME_BITS = 9;
  localparam int unsigned FLAG_BIT   = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LEN_W      = 4;

  localparam logic FLAG_ADDR = 1'b1;
  localparam logic FLAG_DATA = 1'b0;

  // Payload of one serial frame, flag in the MSB so it is shifted out last.
  typedef struct packed {
    logic                flag;
    logic [FLAG_BIT-1:0] payload;
  } frame_t;

endpackage

// File: rtl/uart9_tx_fifo.sv
// Synchronous byte FIFO feeding data frames to the transmitter; flags are registered.
module uart9_tx_fifo
  import uart9_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] pop_data_c,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_d;
  logic              push_ok;
  logic              pop_ok;

  // A push on a full FIFO only lands if a pop frees the slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    count_d = count;
    if (push_ok && !pop_ok) begin
      count_d = count + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign pop_data_c = mem[rd_ptr];

endmodule

// File: rtl/uart9_master_tx.sv
// Sends one address frame followed by cmd_len data frames drawn from the internal FIFO.
module uart9_master_tx
  import uart9_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              fifo_full,
  output logic              fifo_empty,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [BYTE_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        IDX_LAST  = 4'(FRAME_BITS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [3:0]        idx_q, idx_d;
  frame_t            shift_q, shift_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              tx_d, busy_d, done_d;
  logic              last_c, next_data_c, pop_c;
  logic [BYTE_W-1:0] pop_data_c;

  uart9_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (wr_en),
    .push_data  (wr_data),
    .pop        (pop_c),
    .pop_data_c (pop_data_c),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Next-state logic; tx_d is the line level for the cycle after the edge.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rem_d       = rem_q;
    tx_d        = tx;
    busy_d      = busy;
    done_d      = 1'b0;
    next_data_c = 1'b0;
    pop_c       = 1'b0;
    last_c      = (baud_q == BAUD_LAST);

    if (state_q != IDLE && state_q != WAIT) begin
      baud_d = last_c ? '0 : baud_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = START;
          shift_d = '{flag: FLAG_ADDR, payload: cmd_addr};
          rem_d   = cmd_len;
          baud_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (last_c) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (last_c) begin
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            shift_d = frame_t'(shift_q >> 1);
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (last_c) begin
          if (rem_q == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (!fifo_empty) begin
            next_data_c = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!fifo_empty) next_data_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Pop happens on the last stop-bit (or WAIT) cycle so the start bit follows with no gap.
    if (next_data_c) begin
      pop_c   = 1'b1;
      shift_d = '{flag: FLAG_DATA, payload: pop_data_c};
      rem_d   = rem_q - LEN_W'(1);
      baud_d  = '0;
      state_d = START;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rem_q     <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rem_q     <= rem_d;
      tx        <= tx_d;
      busy      <= busy_d;
      done      <= done_d;
      cmd_ready <= !busy_d;
    end
  end

endmodule
